// File: rtl/mips_irq_ctrl_if.sv
// Register port and core handshake between mips_irq_ctrl and coprocessor 0.
`timescale 1ns/1ps
interface mips_irq_ctrl_if #(
    parameter int unsigned ID_W = 5
);
    logic            i_wr_en;
    logic [1:0]      i_addr;
    logic [31:0]     i_wdata;
    logic [31:0]     o_rdata;
    logic            i_irq_ack;
    logic            o_coproc0_interrupt;
    logic [ID_W-1:0] o_irq_id;
    logic            o_busy;

    // Controller side
    modport slave (
        input  i_wr_en, i_addr, i_wdata, i_irq_ack,
        output o_rdata, o_coproc0_interrupt, o_irq_id, o_busy
    );

    // Core side
    modport master (
        output i_wr_en, i_addr, i_wdata, i_irq_ack,
        input  o_rdata, o_coproc0_interrupt, o_irq_id, o_busy
    );
endinterface

// File: rtl/mips_irq_ctrl.sv
// Programmable interrupt controller feeding the MIPS coprocessor 0 interrupt input.
`timescale 1ns/1ps
module mips_irq_ctrl #(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned ID_W  = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_irq_src,
    mips_irq_ctrl_if.slave   bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [1:0] A_MASK    = 2'd0;
    localparam logic [1:0] A_MODE    = 2'd1;
    localparam logic [1:0] A_PENDING = 2'd2;
    localparam logic [1:0] A_ID      = 2'd3;

    logic [N_SRC-1:0] r_s1, r_s2, r_s3;
    logic [N_SRC-1:0] r_mask, r_mode, r_pend;
    logic [1:0]       r_state;
    logic             r_irq;
    logic [ID_W-1:0]  r_id;

    logic [N_SRC-1:0] w_edge, w_clr, w_pend_nxt, w_elig;
    logic [ID_W-1:0]  w_win, w_id_nxt;
    logic             w_id_elig, w_eoi, w_w1c, w_busy, w_irq_nxt;
    logic [1:0]       w_state_nxt;
    logic [31:0]      w_rdata;

    assign w_edge = r_s2 & ~r_s3;
    assign w_elig = r_pend & r_mask;
    assign w_w1c  = bus.i_wr_en && (bus.i_addr == A_PENDING);
    assign w_eoi  = bus.i_wr_en && (bus.i_addr == A_ID) && (r_state == ST_SERVICE);
    assign w_busy = (r_state != ST_IDLE);

    // Three-flop synchroniser on every request line
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= i_irq_src;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Next pending: level sources follow s2, edge sources latch with set-over-clear
    always_comb begin
        w_clr      = '0;
        w_pend_nxt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_clr[i] = (w_w1c && bus.i_wdata[i]) || (w_eoi && (r_id == ID_W'(i)));
            if (r_mode[i]) begin
                w_pend_nxt[i] = w_edge[i] | (r_pend[i] & ~w_clr[i]);
            end else begin
                w_pend_nxt[i] = r_s2[i];
            end
        end
    end

    // Configuration and pending registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mask <= '0;
            r_mode <= '0;
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            if (bus.i_wr_en && (bus.i_addr == A_MASK)) begin
                r_mask <= bus.i_wdata[N_SRC-1:0];
            end
            if (bus.i_wr_en && (bus.i_addr == A_MODE)) begin
                r_mode <= bus.i_wdata[N_SRC-1:0];
            end
        end
    end

    // Fixed-priority pick (source 0 wins) and eligibility of the latched ID
    always_comb begin
        w_win     = '0;
        w_id_elig = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win = ID_W'(i);
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (r_id == ID_W'(i)) begin
                w_id_elig = w_elig[i];
            end
        end
    end

    // Handshake FSM next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_irq_nxt   = r_irq;
        w_id_nxt    = r_id;
        case (r_state)
            ST_IDLE: begin
                if (|w_elig) begin
                    w_state_nxt = ST_REQ;
                    w_irq_nxt   = 1'b1;
                    w_id_nxt    = w_win;
                end
            end
            ST_REQ: begin
                if (bus.i_irq_ack) begin
                    w_state_nxt = ST_SERVICE;
                    w_irq_nxt   = 1'b0;
                end else if (!w_id_elig) begin
                    w_state_nxt = ST_IDLE;
                    w_irq_nxt   = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (w_eoi) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_irq_nxt   = 1'b0;
            end
        endcase
    end

    // Handshake FSM state and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= w_irq_nxt;
            r_id    <= w_id_nxt;
        end
    end

    // Combinational register read
    always_comb begin
        w_rdata = '0;
        case (bus.i_addr)
            A_MASK:    w_rdata = 32'(r_mask);
            A_MODE:    w_rdata = 32'(r_mode);
            A_PENDING: w_rdata = 32'(r_pend);
            A_ID:      w_rdata = 32'(r_id) | {w_busy, 31'd0};
            default:   w_rdata = '0;
        endcase
    end

    assign bus.o_rdata             = w_rdata;
    assign bus.o_coproc0_interrupt = r_irq;
    assign bus.o_irq_id            = r_id;
    assign bus.o_busy              = w_busy;
endmodule
